// File: rtl/fact_ctrl.sv
// Factorial sequencer: iterates prod = cnt * prod through an external multiplier.
// Operands above MAX_N are rejected with err instead of being computed.
module fact_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned MAX_N = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [3:0]       n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       mul_count,
  output logic [WIDTH-1:0] mul_reg,
  input  logic [WIDTH-1:0] mul_out
);

  typedef enum logic [1:0] {StIdle, StChk, StMult, StDone} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   prod_q, prod_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   result_q, result_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      prod_q   <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    err_d    = err_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          cnt_d    = n;
          prod_d   = {{(WIDTH-1){1'b0}}, 1'b1};
          err_d    = 1'b0;
          result_d = '0;
          state_d  = StChk;
        end
      end
      StChk: begin
        if (32'(cnt_q) > MAX_N) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = StDone;
        end else if (cnt_q <= 4'd1) begin
          // n = 0 lands here directly with prod = 1, giving 0! = 1
          result_d = prod_q;
          state_d  = StDone;
        end else begin
          state_d = StMult;
        end
      end
      StMult: begin
        prod_d  = mul_out;
        cnt_d   = cnt_q - 4'd1;
        state_d = StChk;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    err       = err_q;
    result    = result_q;
    mul_count = cnt_q;
    mul_reg   = prod_q;
  end

endmodule

// File: tb/tb_fact_ctrl.sv
// Directed bench for fact_ctrl: vector table of operands plus sequences for
// go-while-busy, go held through DONE, and reset mid-run.
module tb_fact_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [3:0]  n;
  logic        busy, done, err;
  logic [31:0] result, mul_reg, mul_out;
  logic [3:0]  mul_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] mc_q[$];

  always #5 clk = ~clk;

  assign mul_out = 32'(mul_count) * mul_reg;

  fact_ctrl #(.WIDTH(32), .MAX_N(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .n         (n),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .mul_count (mul_count),
    .mul_reg   (mul_reg),
    .mul_out   (mul_out)
  );

  typedef struct {
    logic [3:0]  n;
    logic [31:0] res;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Start a run at the next edge (edge 0), then wait for done, recording
  // mul_count at odd edges where the controller sits in MULT.
  task automatic do_run(input logic [3:0] nv, output int lat);
    lat = -1;
    mc_q.delete();
    @(negedge clk);
    go = 1'b1;
    n  = nv;
    @(posedge clk);
    #1;
    go = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("err_clear_on_accept", 64'(err), 64'd0);
    chk("result_clear_on_accept", 64'(result), 64'd0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (k % 2 == 1) mc_q.push_back(mul_count);
    end
    if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat;
    vecs[0] = '{n: 4'd5,  res: 32'd120,       e: 1'b0, lat: 9};
    vecs[1] = '{n: 4'd0,  res: 32'd1,         e: 1'b0, lat: 1};
    vecs[2] = '{n: 4'd1,  res: 32'd1,         e: 1'b0, lat: 1};
    vecs[3] = '{n: 4'd12, res: 32'h1C8CFC00,  e: 1'b0, lat: 23};
    vecs[4] = '{n: 4'd13, res: 32'd0,         e: 1'b1, lat: 1};
    vecs[5] = '{n: 4'd15, res: 32'd0,         e: 1'b1, lat: 1};
    vecs[6] = '{n: 4'd3,  res: 32'd6,         e: 1'b0, lat: 5};
    vecs[7] = '{n: 4'd2,  res: 32'd2,         e: 1'b0, lat: 3};
    vecs[8] = '{n: 4'd6,  res: 32'd720,       e: 1'b0, lat: 11};

    rst = 1'b1;
    go  = 1'b0;
    n   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_mul_count", 64'(mul_count), 64'd0);
    chk("rst_mul_reg", 64'(mul_reg), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_run(vecs[i].n, lat);
      chk($sformatf("lat_n%0d", vecs[i].n), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("result_n%0d", vecs[i].n), 64'(result), 64'(vecs[i].res));
      chk($sformatf("err_n%0d", vecs[i].n), 64'(err), 64'(vecs[i].e));
      if (vecs[i].n == 4'd12) begin
        chk("mul_count_steps", 64'(mc_q.size()), 64'd11);
        for (int j = 0; j < mc_q.size(); j++)
          chk($sformatf("mul_count_step%0d", j), 64'(mc_q[j]), 64'(12 - j));
      end
      @(posedge clk);
      #1;
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("busy_low_after_done", 64'(busy), 64'd0);
      chk("result_held", 64'(result), 64'(vecs[i].res));
    end

    // go held high through a whole n=6 run: ignored while busy, restarts in IDLE
    @(negedge clk);
    go = 1'b1;
    n  = 4'd6;
    @(posedge clk);
    #1;
    n = 4'd2;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      chk("held_go_no_early_done", 64'(done), 64'd0);
    end
    @(posedge clk);
    #1;
    chk("held_go_done_e11", 64'(done), 64'd1);
    chk("held_go_result_720", 64'(result), 64'd720);
    @(posedge clk);
    #1;
    chk("held_go_idle_e12", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    go = 1'b0;
    chk("held_go_restart_e13", 64'(busy), 64'd1);
    chk("held_go_result_clear", 64'(result), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("second_run_no_early_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    chk("second_run_done_e16", 64'(done), 64'd1);
    chk("second_run_result", 64'(result), 64'd2);
    @(posedge clk);

    // reset during MULT of an n=7 run
    @(negedge clk);
    go = 1'b1;
    n  = 4'd7;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_mul_count", 64'(mul_count), 64'd6);
    chk("pre_rst_mul_reg", 64'(mul_reg), 64'd7);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_mul_reg", 64'(mul_reg), 64'd0);
    chk("abort_mul_count", 64'(mul_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (done) chk("abort_stray_done", 64'(done), 64'd0);
    end
    chk("abort_still_idle", 64'(busy), 64'd0);
    do_run(4'd4, lat);
    chk("post_abort_lat", 64'(lat), 64'd7);
    chk("post_abort_result", 64'(result), 64'd24);
    chk("post_abort_err", 64'(err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
